// File: rtl/seq_divider_if.sv
// Operand/result bundle between the stimulus source and seq_divider.
// master drives operands and start; slave returns results and status.
interface seq_divider_if #(
    parameter int width = 24
);
    logic             start;
    logic [width-1:0] A;
    logic [width-1:0] B;
    logic [width-1:0] Q;
    logic [width-1:0] R;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, dbz
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, dbz
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds a SIGN cycle).
module seq_divider #(
    parameter int width = 24,
    parameter int cntw  = 5
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, SIGN, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
`endif

    state_t           state;
    state_t           nxt;
    logic [width-1:0] dvd;
    logic [width-1:0] dvs;
    logic [width-1:0] p;
    logic [cntw-1:0]  cnt;
    logic             dbzr;
    logic [width:0]   pt;
    logic [width:0]   diff;
    logic             ge;
    logic [width-1:0] ma;
    logic [width-1:0] mb;
    logic             bz;

`ifdef DIV_SIGNED_EN
    logic qneg;
    logic rneg;

    assign ma = bus.A[width-1] ? -bus.A : bus.A;
    assign mb = bus.B[width-1] ? -bus.B : bus.B;
`else
    assign ma = bus.A;
    assign mb = bus.B;
`endif

    assign bz = (bus.B == '0);

    // Extra bit keeps the trial subtraction from overflowing.
    assign pt   = {p, dvd[width-1]};
    assign diff = pt - {1'b0, dvs};
    assign ge   = ~diff[width];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (bus.start) nxt = bz ? FIN : RUN;
`ifdef DIV_SIGNED_EN
            RUN:  if (cnt == cntw'(1)) nxt = SIGN;
            SIGN: nxt = FIN;
`else
            RUN:  if (cnt == cntw'(1)) nxt = FIN;
`endif
            FIN:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd      <= '0;
            dvs      <= '0;
            p        <= '0;
            cnt      <= '0;
            dbzr     <= 1'b0;
            bus.Q    <= '0;
            bus.R    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dbz  <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg     <= 1'b0;
            rneg     <= 1'b0;
`endif
        end else begin
            bus.busy <= (nxt != IDLE);
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    cnt <= cntw'(width);
                    dvs <= mb;
`ifdef DIV_SIGNED_EN
                    qneg <= bus.A[width-1] ^ bus.B[width-1];
                    rneg <= bus.A[width-1];
`endif
                    if (bz) begin
                        dvd  <= '1;
                        p    <= bus.A;
                        dbzr <= 1'b1;
                    end else begin
                        dvd  <= ma;
                        p    <= '0;
                        dbzr <= 1'b0;
                    end
                end
                RUN: begin
                    dvd <= {dvd[width-2:0], ge};
                    p   <= ge ? diff[width-1:0] : pt[width-1:0];
                    cnt <= cnt - cntw'(1);
                end
`ifdef DIV_SIGNED_EN
                SIGN: begin
                    if (qneg) dvd <= -dvd;
                    if (rneg) p <= -p;
                end
`endif
                FIN: begin
                    bus.Q    <= dvd;
                    bus.R    <= p;
                    bus.dbz  <= dbzr;
                    bus.done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (width 24).
// Expected values are hand-computed quotients, remainders and latencies.
module tb_seq_divider;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;

    seq_divider_if #(.width(24)) bus ();

    seq_divider #(.width(24), .cntw(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_SIGNED_EN
    localparam int LAT = 26;
`else
    localparam int LAT = 25;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge, return edges from start edge to done.
    task automatic run(input logic [23:0] a, input logic [23:0] b,
                       output int lat);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic op(input string tag, input logic [23:0] a,
                      input logic [23:0] b, input int elat,
                      input logic [23:0] eq, input logic [23:0] er,
                      input logic edbz);
        int lat;
        run(a, b, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, bus.Q, eq);
        check({tag, "_r"}, bus.R, er);
        check({tag, "_dbz"}, bus.dbz, edbz);
        check({tag, "_busy"}, bus.busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, bus.done, 0);
    endtask

    initial begin
        int ndone;
        int at;
        int k;
        nchk = 0;
        nerr = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #22;
        check("rst_q", bus.Q, 0);
        check("rst_r", bus.R, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.dbz, 0);
        @(negedge clk);
        reset = 1'b1;

        op("basic", 24'h2625A0, 24'h001068, LAT, 24'h000253, 24'h0003E8, 0);
        op("dbz", 24'h000064, 24'h000000, 1, 24'hFFFFFF, 24'h000064, 1);
        op("small", 24'd5, 24'd9, LAT, 24'd0, 24'd5, 0);
        op("eq", 24'hFFFFFF, 24'hFFFFFF, LAT, 24'd1, 24'd0, 0);
`ifdef DIV_SIGNED_EN
        op("sgn", 24'hFFFFF9, 24'd2, LAT, 24'hFFFFFD, 24'hFFFFFF, 0);
        op("wrap", 24'h800000, 24'hFFFFFF, LAT, 24'h800000, 24'd0, 0);
        op("sdbz", 24'hFFFFF9, 24'd0, 1, 24'hFFFFFF, 24'hFFFFF9, 1);
`else
        op("big", 24'hFFFFF9, 24'd2, LAT, 24'h7FFFFC, 24'd1, 0);
        op("neg1", 24'h800000, 24'hFFFFFF, LAT, 24'd0, 24'h800000, 0);
`endif

        // Operand changes and start pulses during RUN are ignored.
        @(negedge clk);
        bus.A = 24'hFFFFFF;
        bus.B = 24'h000001;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        at = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                bus.A = 24'd5;
                bus.B = 24'd3;
                bus.start = 1'b1;
            end
            if (i == 11) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                at = i;
            end
        end
        check("ign_ndone", ndone, 1);
        check("ign_lat", at, LAT);
        check("ign_q", bus.Q, 24'hFFFFFF);
        check("ign_r", bus.R, 24'd0);

        // Asynchronous abort mid-division.
        @(negedge clk);
        bus.A = 24'd1000;
        bus.B = 24'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_q", bus.Q, 0);
        check("abort_r", bus.R, 0);
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort_nodone", ndone, 0);
        op("after", 24'd1000, 24'd7, LAT, 24'd142, 24'd6, 0);

        // Start held high: back-to-back ops with one idle cycle.
        @(negedge clk);
        bus.A = 24'd10;
        bus.B = 24'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        for (int i = 1; i <= 3 * (LAT + 1) + 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                check("hold_at", i, LAT + k * (LAT + 1));
                check("hold_q", bus.Q, 24'd3);
                check("hold_r", bus.R, 24'd1);
                k++;
                if (k == 3) begin
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("hold_n", k, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nerr);
        $finish;
    end

endmodule
